dmem_responder: RTL and testbench



---
 rtl/dmem_responder_pkg.sv | 29 ++
 rtl/dmem_array.sv | 47 ++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 tb/tb_dmem_responder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package dmem_responder_pkg;

  // Access size encoding as carried on req_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BAD  = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  // Responder FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Number of bytes touched by an access; the illegal encoding touches none.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_bytes = 3'd1;
      SZ_HALF: size_to_bytes = 3'd2;
      SZ_WORD: size_to_bytes = 3'd4;
      default: size_to_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Big-endian byte-array storage: 4-byte read window starting at i_addr and
// per-lane write enables. Lane 0 is the byte at i_addr and maps to bits 0..7.
module dmem_array #(
  parameter int unsigned SIZE = 32768
) (
  input  logic        clk,
  input  logic [0:31] i_addr,
  input  logic [0:3]  i_we,
  input  logic [0:31] i_wdata,
  output logic [0:31] o_rdata
);

  localparam int AW = $clog2(SIZE);

  logic [0:7]  r_mem [SIZE];
  logic [32:0] w_lane_sum [4];
  logic [0:3]  w_lane_ok;

  // Per-lane byte address, computed one bit wider so the top of the address
  // space cannot wrap back into the array.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_lane_sum[k] = {1'b0, i_addr} + 33'(k);
      w_lane_ok[k]  = (w_lane_sum[k] < 33'(SIZE));
    end
  end

  // Read window; lanes beyond the array read as zero.
  always_comb begin
    o_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_lane_ok[k]) begin
        o_rdata[8*k +: 8] = r_mem[w_lane_sum[k][AW-1:0]];
      end
    end
  end

  // Byte-lane writes; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k] && w_lane_ok[k]) begin
        r_mem[w_lane_sum[k][AW-1:0]] <= i_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, waits LATENCY
// cycles, commits on the edge entering RESP and holds the response until taken.
// LATENCY must lie in 1..15.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned SIZE    = 32768,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [0:31] req_addr,
  input  logic [0:31] req_wdata,
  input  logic [0:1]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [0:31] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [0:31] r_addr;
  logic [0:31] r_wdata;
  logic [0:1]  r_size;
  logic        r_signed;
  logic        r_err;
  logic [0:31] r_resp_rdata;
  logic        r_resp_err;

  logic        w_accept;
  logic        w_commit;
  logic        w_req_err;
  logic [32:0] w_req_end;
  logic        w_in_idle;
  logic        w_c_we;
  logic [0:31] w_c_addr;
  logic [0:31] w_c_wdata;
  logic [0:1]  w_c_size;
  logic        w_c_signed;
  logic        w_c_err;
  logic [0:3]  w_lane_we;
  logic [0:31] w_lane_wdata;
  logic [0:31] w_rd;
  logic [0:31] w_load_data;

  assign w_in_idle = (r_state == ST_IDLE);
  assign w_accept  = w_in_idle && req_valid;
  assign w_commit  = (r_state != ST_RESP) && (w_next_state == ST_RESP);

  // Request legality: bad size, misalignment, or running past the array end.
  always_comb begin
    w_req_end = {1'b0, req_addr} + 33'(size_to_bytes(req_size));
    w_req_err = 1'b0;
    if (req_size == SZ_BAD)                                  w_req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[30:31] != 2'b00)) w_req_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[31])               w_req_err = 1'b1;
    if (w_req_end > 33'(SIZE))                               w_req_err = 1'b1;
  end

  // Commit operands: with LATENCY=1 the commit is the accept edge, so the
  // live request is used instead of the latched copy.
  always_comb begin
    w_c_we     = w_in_idle ? req_we     : r_we;
    w_c_addr   = w_in_idle ? req_addr   : r_addr;
    w_c_wdata  = w_in_idle ? req_wdata  : r_wdata;
    w_c_size   = w_in_idle ? req_size   : r_size;
    w_c_signed = w_in_idle ? req_signed : r_signed;
    w_c_err    = w_in_idle ? w_req_err  : r_err;
  end

  // Steer right-justified store data onto the leading byte lanes.
  always_comb begin
    w_lane_we    = 4'b0000;
    w_lane_wdata = w_c_wdata;
    case (w_c_size)
      SZ_WORD: w_lane_we = 4'b1111;
      SZ_HALF: begin
        w_lane_we    = 4'b1100;
        w_lane_wdata = {w_c_wdata[16:31], 16'h0000};
      end
      SZ_BYTE: begin
        w_lane_we    = 4'b1000;
        w_lane_wdata = {w_c_wdata[24:31], 24'h000000};
      end
      default: w_lane_we = 4'b0000;
    endcase
    if (!(w_commit && w_c_we && !w_c_err)) w_lane_we = 4'b0000;
  end

  dmem_array #(.SIZE(SIZE)) u_array (
    .clk     (clk),
    .i_addr  (w_c_addr),
    .i_we    (w_lane_we),
    .i_wdata (w_lane_wdata),
    .o_rdata (w_rd)
  );

  // Load result with optional sign extension from the leading byte's MSB.
  always_comb begin
    case (w_c_size)
      SZ_HALF: w_load_data = {{16{w_c_signed & w_rd[0]}}, w_rd[0:15]};
      SZ_BYTE: w_load_data = {{24{w_c_signed & w_rd[0]}}, w_rd[0:7]};
      default: w_load_data = w_rd;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_next_state = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_next_state = ST_RESP;
      ST_RESP: if (resp_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response capture at the commit edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_err        <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we     <= req_we;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_err    <= w_req_err;
        r_cnt    <= CNT_INIT;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_resp_rdata <= (w_c_we || w_c_err) ? 32'h0 : w_load_data;
        r_resp_err   <= w_c_err;
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign busy       = (r_state != ST_IDLE);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with LATENCY=3 and SIZE=32768.
module tb_dmem_responder;

  localparam int unsigned SIZE    = 32768;
  localparam int unsigned LATENCY = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [0:31] req_addr = '0;
  logic [0:31] req_wdata = '0;
  logic [0:1]  req_size = 2'd3;
  logic        req_signed = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [0:31] resp_rdata;
  logic        resp_err;
  logic        busy;

  int passCount = 0;
  int checkCount = 0;

  dmem_responder #(.SIZE(SIZE), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_signed (req_signed),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one request from IDLE, count edges from acceptance to resp_valid
  // (the accept edge counts as 1), then take the response. lat=-1 on timeout.
  task automatic do_access(input logic we, input logic [0:31] addr, input logic [0:31] wdata,
                           input logic [0:1] size, input logic sgn,
                           output logic [0:31] rdata, output logic err, output int lat);
    rdata = '0;
    err = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_size = size; req_signed = sgn;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!resp_valid) lat = -1;
    rdata = resp_rdata;
    err = resp_err;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checkCount++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); else passCount++;
    checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); else passCount++;
    checkCount++; if (resp_rdata !== 32'h0) $display("[TB] FAIL reset_resp_rdata: got %h expected 00000000", resp_rdata); else passCount++;
    checkCount++; if (resp_err !== 1'b0) $display("[TB] FAIL reset_resp_err: got %b expected 0", resp_err); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [0:31] rd; logic er; int lat;
    do_access(1'b1, 32'h100, 32'hDEADBEEF, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (lat !== 3) $display("[TB] FAIL st_word_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL st_word_err: got %b expected 0", er); else passCount++;
    checkCount++; if (rd !== 32'h0) $display("[TB] FAIL st_word_rdata: got %h expected 00000000", rd); else passCount++;
    do_access(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (lat !== 3) $display("[TB] FAIL ld_word_latency: got %0d expected 3", lat); else passCount++;
    checkCount++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL ld_word_rdata: got %h expected deadbeef", rd); else passCount++;
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL ld_word_err: got %b expected 0", er); else passCount++;
  endtask

  task automatic test_byte_sign();
    logic [0:31] rd; logic er; int lat;
    do_access(1'b1, 32'h200, 32'h11223344, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL pre_word_err: got %b expected 0", er); else passCount++;
    do_access(1'b1, 32'h201, 32'h000000F0, 2'd0, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL st_byte_err: got %b expected 0", er); else passCount++;
    do_access(1'b0, 32'h201, 32'h0, 2'd0, 1'b1, rd, er, lat);
    checkCount++; if (rd !== 32'hFFFFFFF0) $display("[TB] FAIL ld_byte_signed: got %h expected fffffff0", rd); else passCount++;
    do_access(1'b0, 32'h201, 32'h0, 2'd0, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'h000000F0) $display("[TB] FAIL ld_byte_unsigned: got %h expected 000000f0", rd); else passCount++;
    do_access(1'b0, 32'h200, 32'h0, 2'd1, 1'b1, rd, er, lat);
    checkCount++; if (rd !== 32'h000011F0) $display("[TB] FAIL ld_half_pos_signed: got %h expected 000011f0", rd); else passCount++;
  endtask

  task automatic test_half();
    logic [0:31] rd; logic er; int lat;
    do_access(1'b1, 32'h202, 32'h00008001, 2'd1, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL st_half_err: got %b expected 0", er); else passCount++;
    do_access(1'b0, 32'h200, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'h11F08001) $display("[TB] FAIL half_word_view: got %h expected 11f08001", rd); else passCount++;
    do_access(1'b0, 32'h202, 32'h0, 2'd1, 1'b1, rd, er, lat);
    checkCount++; if (rd !== 32'hFFFF8001) $display("[TB] FAIL ld_half_signed: got %h expected ffff8001", rd); else passCount++;
  endtask

  task automatic test_errors();
    logic [0:31] rd; logic er; int lat;
    do_access(1'b1, 32'h103, 32'hCAFEF00D, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL misaligned_word_err: got %b expected 1", er); else passCount++;
    checkCount++; if (rd !== 32'h0) $display("[TB] FAIL misaligned_word_rdata: got %h expected 00000000", rd); else passCount++;
    do_access(1'b1, 32'h100, 32'h12345678, 2'd2, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL bad_size_err: got %b expected 1", er); else passCount++;
    do_access(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL err_mem_unchanged: got %h expected deadbeef", rd); else passCount++;
    do_access(1'b0, SIZE - 2, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL word_at_size_m2_err: got %b expected 1", er); else passCount++;
    checkCount++; if (rd !== 32'h0) $display("[TB] FAIL word_at_size_m2_rdata: got %h expected 00000000", rd); else passCount++;
    do_access(1'b0, SIZE - 4, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b0) $display("[TB] FAIL word_at_size_m4_err: got %b expected 0", er); else passCount++;
    do_access(1'b0, SIZE, 32'h0, 2'd0, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL byte_at_size_err: got %b expected 1", er); else passCount++;
    do_access(1'b0, 32'hFFFFFFFF, 32'h0, 2'd0, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL byte_no_wrap_err: got %b expected 1", er); else passCount++;
    do_access(1'b0, 32'h101, 32'h0, 2'd1, 1'b0, rd, er, lat);
    checkCount++; if (er !== 1'b1) $display("[TB] FAIL misaligned_half_err: got %b expected 1", er); else passCount++;
  endtask

  task automatic test_backpressure();
    logic [0:31] rd; logic er; int lat; int n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd3; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checkCount++; if (resp_valid !== 1'b1) $display("[TB] FAIL bp_resp_timeout: got %b expected 1", resp_valid); else passCount++;
    for (int i = 0; i < 5; i++) begin
      req_valid = (i % 2 == 0); req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h0;
      @(posedge clk); #1;
      checkCount++; if (resp_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid_%0d: got %b expected 1", i, resp_valid); else passCount++;
      checkCount++; if (resp_rdata !== 32'hDEADBEEF) $display("[TB] FAIL bp_hold_rdata_%0d: got %h expected deadbeef", i, resp_rdata); else passCount++;
      checkCount++; if (req_ready !== 1'b0) $display("[TB] FAIL bp_req_ready_%0d: got %b expected 0", i, req_ready); else passCount++;
      checkCount++; if (busy !== 1'b1) $display("[TB] FAIL bp_busy_%0d: got %b expected 1", i, busy); else passCount++;
    end
    req_valid = 1'b0; req_we = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL bp_release_valid: got %b expected 0", resp_valid); else passCount++;
    checkCount++; if (req_ready !== 1'b1) $display("[TB] FAIL bp_release_ready: got %b expected 1", req_ready); else passCount++;
    do_access(1'b0, 32'h100, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL bp_no_second_accept: got %h expected deadbeef", rd); else passCount++;
  endtask

  task automatic test_reset_in_wait();
    logic [0:31] rd; logic er; int lat;
    do_access(1'b1, 32'h300, 32'h01020304, 2'd3, 1'b0, rd, er, lat);
    do_access(1'b0, 32'h300, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'h01020304) $display("[TB] FAIL rw_old_value: got %h expected 01020304", rd); else passCount++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'hAAAAAAAA; req_size = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    checkCount++; if (busy !== 1'b1) $display("[TB] FAIL rw_busy_in_wait: got %b expected 1", busy); else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++; if (req_ready !== 1'b1) $display("[TB] FAIL rw_req_ready: got %b expected 1", req_ready); else passCount++;
    checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL rw_resp_valid: got %b expected 0", resp_valid); else passCount++;
    checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rw_busy: got %b expected 0", busy); else passCount++;
    checkCount++; if (resp_rdata !== 32'h0) $display("[TB] FAIL rw_rdata: got %h expected 00000000", resp_rdata); else passCount++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL rw_no_response: got %b expected 0", resp_valid); else passCount++;
    do_access(1'b0, 32'h300, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'h01020304) $display("[TB] FAIL rw_store_dropped: got %h expected 01020304", rd); else passCount++;
  endtask

  task automatic test_reset_in_resp();
    logic [0:31] rd; logic er; int lat; int n;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h304; req_wdata = 32'h0BADF00D; req_size = 2'd3;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
    checkCount++; if (resp_valid !== 1'b1) $display("[TB] FAIL rr_resp_timeout: got %b expected 1", resp_valid); else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++; if (resp_valid !== 1'b0) $display("[TB] FAIL rr_resp_dropped: got %b expected 0", resp_valid); else passCount++;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 32'h304, 32'h0, 2'd3, 1'b0, rd, er, lat);
    checkCount++; if (rd !== 32'h0BADF00D) $display("[TB] FAIL rr_store_kept: got %h expected 0badf00d", rd); else passCount++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_sign();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_in_wait();
    test_reset_in_resp();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
